// File: rtl/data_pipe_pkg.sv
// Shared types and sizes for the data_pipe interconnect family.
package data_pipe_pkg;

  typedef enum logic [1:0] {ARB, XFER} s8m1_state_e;

  localparam int NUM_PORTS = 8;
  localparam int PORT_W    = 3;

endpackage

// File: rtl/data_inf.sv
// Valid/ready stream bundle carrying DSIZE-bit data.
interface data_inf #(parameter int DSIZE = 8) ();

  logic             valid;
  logic [DSIZE-1:0] data;
  logic             ready;

  modport master (output valid, output data, input ready);
  modport slaver (input valid, input data, output ready);

endinterface

// File: rtl/data_pipe_skid2.sv
// Two-entry FIFO that registers the merged stream so the downstream ready
// never reaches an upstream ready combinationally.
module data_pipe_skid2 #(
  parameter int DSIZE = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             push,
  input  logic [DSIZE-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [DSIZE-1:0] head
);

  logic [DSIZE-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop && (count != 2'd0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/data_pipe_interconnect_s8_m1.sv
// 8-to-1 stream merge with held grants (up to HOLD_MAX beats) and a 2-entry output buffer.
// Define DATA_PIPE_S8M1_FIXED_PRIO_EN for fixed priority (s00 highest); default is round-robin.
//
// state | meaning
// ARB   | no grant held; pick a valid source (all upstream ready low)
// XFER  | grant held on curr_path; forward its beats into the buffer
module data_pipe_interconnect_s8_m1 import data_pipe_pkg::*; #(
  parameter int DSIZE    = 8,
  parameter int HOLD_MAX = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              clk_en,
  data_inf.slaver           s00,
  data_inf.slaver           s01,
  data_inf.slaver           s02,
  data_inf.slaver           s03,
  data_inf.slaver           s04,
  data_inf.slaver           s05,
  data_inf.slaver           s06,
  data_inf.slaver           s07,
  data_inf.master           m00,
  output logic [PORT_W-1:0] curr_path,
  output logic              grant_vld
);

  logic [NUM_PORTS-1:0] s_valid;
  logic [NUM_PORTS-1:0] s_ready;
  logic [DSIZE-1:0]     s_data [NUM_PORTS];

  assign s_valid = {s07.valid, s06.valid, s05.valid, s04.valid,
                    s03.valid, s02.valid, s01.valid, s00.valid};
  assign s_data[0] = s00.data;
  assign s_data[1] = s01.data;
  assign s_data[2] = s02.data;
  assign s_data[3] = s03.data;
  assign s_data[4] = s04.data;
  assign s_data[5] = s05.data;
  assign s_data[6] = s06.data;
  assign s_data[7] = s07.data;
  assign s00.ready = s_ready[0];
  assign s01.ready = s_ready[1];
  assign s02.ready = s_ready[2];
  assign s03.ready = s_ready[3];
  assign s04.ready = s_ready[4];
  assign s05.ready = s_ready[5];
  assign s06.ready = s_ready[6];
  assign s07.ready = s_ready[7];

  s8m1_state_e       state, state_d;
  logic [PORT_W-1:0] path_d;
  logic              grant_d;
  logic [7:0]        beat_cnt, beat_d, beat_inc;
  logic              win_found;
  logic [PORT_W-1:0] win_idx;
  logic              push;
  logic              pop;
  logic [1:0]        buf_count;
  logic [DSIZE-1:0]  buf_head;

`ifdef DATA_PIPE_S8M1_FIXED_PRIO_EN
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (s_valid[i]) begin
        win_found = 1'b1;
        win_idx   = PORT_W'(i);
      end
    end
  end
`else
  logic [PORT_W-1:0] rr_ptr;
  logic [PORT_W-1:0] cand;

  // Search wraps naturally through the 3-bit index starting at rr_ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = rr_ptr + PORT_W'(i);
      if (!win_found && s_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (state == ARB && clk_en && win_found) begin
      rr_ptr <= win_idx + PORT_W'(1);
    end
  end
`endif

  always_comb begin
    state_d  = state;
    path_d   = curr_path;
    grant_d  = grant_vld;
    beat_d   = beat_cnt;
    beat_inc = beat_cnt + 8'd1;
    s_ready  = '0;
    push     = 1'b0;
    case (state)
      ARB: begin
        if (clk_en && win_found) begin
          state_d = XFER;
          path_d  = win_idx;
          grant_d = 1'b1;
          beat_d  = '0;
        end
      end
      XFER: begin
        s_ready[curr_path] = clk_en && (buf_count != 2'd2);
        if (clk_en) begin
          if (!s_valid[curr_path]) begin
            state_d = ARB;
            grant_d = 1'b0;
          end else if (buf_count != 2'd2) begin
            push   = 1'b1;
            beat_d = beat_inc;
            if (beat_inc == 8'(HOLD_MAX)) begin
              state_d = ARB;
              grant_d = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d = ARB;
        grant_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= ARB;
      curr_path <= '0;
      grant_vld <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      state     <= state_d;
      curr_path <= path_d;
      grant_vld <= grant_d;
      beat_cnt  <= beat_d;
    end
  end

  assign m00.valid = clk_en && (buf_count != 2'd0);
  assign m00.data  = buf_head;
  assign pop       = m00.valid && m00.ready;

  data_pipe_skid2 #(.DSIZE(DSIZE)) u_skid (
    .clock     (clock),
    .rst       (rst),
    .push      (push),
    .push_data (s_data[curr_path]),
    .pop       (pop),
    .count     (buf_count),
    .head      (buf_head)
  );

endmodule

// File: tb/tb_data_pipe_interconnect_s8_m1.sv
// Scoreboard bench for the 8-to-1 merge (round-robin build).
module tb_data_pipe_interconnect_s8_m1;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b1;
  logic       m00_ready = 1'b1;
  logic [7:0] tb_valid = '0;
  logic [7:0] tb_data [8];
  logic [7:0] tb_ready;
  logic [7:0] acc = '0;
  logic       m00_valid;
  logic [7:0] m00_data;
  logic [2:0] curr_path;
  logic       grant_vld;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0] src_q [8][$];
  logic [7:0] exp_q [$];
  int acc_cyc [$];
  int out_cyc [$];
  int gap_q [$];
  int grant_q [$];
  int low_run = 0;
  bit seen_grant = 0;
  bit prev_grant = 0;

  data_inf #(.DSIZE(8)) s_if [8] ();
  data_inf #(.DSIZE(8)) m_if ();

  for (genvar g = 0; g < 8; g++) begin : g_src
    assign s_if[g].valid = tb_valid[g];
    assign s_if[g].data  = tb_data[g];
    assign tb_ready[g]   = s_if[g].ready;
  end
  assign m_if.ready = m00_ready;
  assign m00_valid  = m_if.valid;
  assign m00_data   = m_if.data;

  data_pipe_interconnect_s8_m1 #(.DSIZE(8), .HOLD_MAX(16)) dut (
    .clock     (clock),
    .rst       (rst),
    .clk_en    (clk_en),
    .s00       (s_if[0]),
    .s01       (s_if[1]),
    .s02       (s_if[2]),
    .s03       (s_if[3]),
    .s04       (s_if[4]),
    .s05       (s_if[5]),
    .s06       (s_if[6]),
    .s07       (s_if[7]),
    .m00       (m_if),
    .curr_path (curr_path),
    .grant_vld (grant_vld)
  );

  always #5 clock = ~clock;

  // Source drivers: present queue heads, advance on accepted beats.
  always @(posedge clock) begin
    #1;
    for (int i = 0; i < 8; i++) begin
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      tb_valid[i] = (src_q[i].size() > 0);
      tb_data[i]  = tb_valid[i] ? src_q[i][0] : 8'h00;
    end
  end

  // Monitor: record handshakes, check output order, track grants.
  always @(negedge clock) begin
    logic [7:0] e;
    cyc++;
    for (int i = 0; i < 8; i++) begin
      acc[i] = tb_valid[i] & tb_ready[i] & clk_en;
      if (acc[i]) acc_cyc.push_back(cyc);
    end
    if (m00_valid && m00_ready && clk_en) begin
      out_cyc.push_back(cyc);
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got %02h, wanted no beat", m00_data);
      end else begin
        e = exp_q.pop_front();
        if (m00_data !== e) begin
          n_err++;
          $display("FAIL sb_data: got %02h, wanted %02h", m00_data, e);
        end
      end
    end
    if (grant_vld) begin
      if (!prev_grant) begin
        if (seen_grant) gap_q.push_back(low_run);
        grant_q.push_back(int'(curr_path));
      end
      seen_grant = 1;
      low_run = 0;
    end else begin
      low_run++;
    end
    prev_grant = grant_vld;
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clk_en = 1'b1;
    m00_ready = 1'b1;
    for (int i = 0; i < 8; i++) src_q[i].delete();
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    acc_cyc.delete();
    out_cyc.delete();
    gap_q.delete();
    grant_q.delete();
    seen_grant = 0;
  endtask

  task automatic wait_drain(input int budget);
    for (int n = 0; n < budget && exp_q.size() > 0; n++) tick();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clk_en = 1'b1;
    src_q[0].push_back(8'h5A);
    tick();
    tick();
    n_vec++;
    if (m00_valid !== 1'b0 || grant_vld !== 1'b0 || curr_path !== 3'd0 || tb_ready !== 8'h00) begin
      n_err++;
      $display("FAIL reset: got valid=%b grant=%b path=%0d ready=%02h, wanted 0 0 0 00",
               m00_valid, grant_vld, curr_path, tb_ready);
    end
    src_q[0].delete();
    tick();
    tick();
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    src_q[3].push_back(8'h11);
    src_q[3].push_back(8'h22);
    src_q[3].push_back(8'h33);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    tick();
    tick();
    n_vec++;
    if (grant_vld !== 1'b1 || curr_path !== 3'd3) begin
      n_err++;
      $display("FAIL single_path: got grant=%b path=%0d, wanted 1 3", grant_vld, curr_path);
    end
    wait_drain(50);
    n_vec++;
    if (exp_q.size() != 0 || out_cyc.size() != 3 || acc_cyc.size() != 3) begin
      n_err++;
      $display("FAIL single_count: got out=%0d acc=%0d left=%0d, wanted 3 3 0",
               out_cyc.size(), acc_cyc.size(), exp_q.size());
    end else begin
      n_vec++;
      if (out_cyc[0] - acc_cyc[0] != 1) begin
        n_err++;
        $display("FAIL single_latency: got %0d cycles, wanted 1", out_cyc[0] - acc_cyc[0]);
      end
      n_vec++;
      if (out_cyc[2] - out_cyc[0] != 2) begin
        n_err++;
        $display("FAIL single_rate: got span %0d, wanted 2", out_cyc[2] - out_cyc[0]);
      end
    end
  endtask

  task automatic test_contention();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      src_q[0].push_back(8'h01 + 8'(i));
      src_q[5].push_back(8'h51 + 8'(i));
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h01 + 8'(i));
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h51 + 8'(i));
    wait_drain(100);
    src_q[1].push_back(8'h1A);
    src_q[6].push_back(8'h6A);
    exp_q.push_back(8'h6A);
    exp_q.push_back(8'h1A);
    wait_drain(100);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL contention_drain: got %0d beats left, wanted 0", exp_q.size());
    end
    n_vec++;
    if (grant_q.size() != 4 || grant_q[0] != 0 || grant_q[1] != 5 || grant_q[2] != 6 || grant_q[3] != 1) begin
      n_err++;
      $display("FAIL contention_grants: got %p, wanted '{0,5,6,1}", grant_q);
    end
  endtask

  task automatic test_hold_max();
    int rem2, rem6, p2, p6;
    bit turn2;
    do_reset();
    for (int i = 0; i < 40; i++) src_q[2].push_back(8'(i));
    for (int i = 0; i < 20; i++) src_q[6].push_back(8'h80 + 8'(i));
    rem2 = 40; rem6 = 20; p2 = 0; p6 = 0; turn2 = 1;
    while (rem2 > 0 || rem6 > 0) begin
      if ((turn2 && rem2 > 0) || rem6 == 0) begin
        for (int k = 0; k < 16 && rem2 > 0; k++) begin
          exp_q.push_back(8'(p2)); p2++; rem2--;
        end
        turn2 = 0;
      end else begin
        for (int k = 0; k < 16 && rem6 > 0; k++) begin
          exp_q.push_back(8'h80 + 8'(p6)); p6++; rem6--;
        end
        turn2 = 1;
      end
    end
    wait_drain(300);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL hold_drain: got %0d beats left, wanted 0", exp_q.size());
    end
    n_vec++;
    if (grant_q.size() != 5 || grant_q[0] != 2 || grant_q[1] != 6 || grant_q[2] != 2
        || grant_q[3] != 6 || grant_q[4] != 2) begin
      n_err++;
      $display("FAIL hold_grants: got %p, wanted '{2,6,2,6,2}", grant_q);
    end
    for (int i = 0; i < gap_q.size(); i++) begin
      n_vec++;
      if (gap_q[i] != 1) begin
        n_err++;
        $display("FAIL hold_gap: gap %0d got %0d cycles, wanted 1", i, gap_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    m00_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      src_q[1].push_back(8'hA0 + 8'(i));
      exp_q.push_back(8'hA0 + 8'(i));
    end
    repeat (8) tick();
    n_vec++;
    if (acc_cyc.size() != 2 || tb_ready[1] !== 1'b0 || m00_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_stall: got acc=%0d ready1=%b valid=%b, wanted 2 0 1",
               acc_cyc.size(), tb_ready[1], m00_valid);
    end
    m00_ready = 1'b1;
    wait_drain(100);
    n_vec++;
    if (exp_q.size() != 0 || out_cyc.size() != 6) begin
      n_err++;
      $display("FAIL bp_drain: got out=%0d left=%0d, wanted 6 0", out_cyc.size(), exp_q.size());
    end
  endtask

  task automatic test_clk_en();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      src_q[3].push_back(8'hC1 + 8'(i));
      exp_q.push_back(8'hC1 + 8'(i));
    end
    for (int k = 0; k < 14; k++) begin
      clk_en = (k % 2 == 0);
      #1;
      if (!clk_en) begin
        n_vec++;
        if (m00_valid !== 1'b0 || tb_ready !== 8'h00) begin
          n_err++;
          $display("FAIL clk_en_low: got valid=%b ready=%02h, wanted 0 00", m00_valid, tb_ready);
        end
      end
      tick();
    end
    clk_en = 1'b1;
    wait_drain(100);
    n_vec++;
    if (exp_q.size() != 0 || out_cyc.size() != 4) begin
      n_err++;
      $display("FAIL clk_en_drain: got out=%0d left=%0d, wanted 4 0", out_cyc.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    int n;
    do_reset();
    m00_ready = 1'b0;
    src_q[4].push_back(8'hD1);
    src_q[4].push_back(8'hD2);
    src_q[4].push_back(8'hD3);
    n = 0;
    while (acc_cyc.size() < 2 && n < 50) begin
      tick();
      n++;
    end
    n_vec++;
    if (acc_cyc.size() != 2) begin
      n_err++;
      $display("FAIL rst_mid_fill: got %0d accepted, wanted 2", acc_cyc.size());
    end
    rst = 1'b1;
    src_q[4].delete();
    tick();
    rst = 1'b0;
    n_vec++;
    if (m00_valid !== 1'b0 || grant_vld !== 1'b0 || curr_path !== 3'd0) begin
      n_err++;
      $display("FAIL rst_mid_state: got valid=%b grant=%b path=%0d, wanted 0 0 0",
               m00_valid, grant_vld, curr_path);
    end
    m00_ready = 1'b1;
    repeat (6) tick();
    n_vec++;
    if (out_cyc.size() != 0 || m00_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_discard: got %0d beats out, wanted 0", out_cyc.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) tb_data[i] = 8'h00;
    test_reset();
    test_single();
    test_contention();
    test_hold_max();
    test_backpressure();
    test_clk_en();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_pipe_interconnect_s8_m1.md
Name: data_pipe_interconnect_S8_M1

Overview:
- 8-to-1 merge stage that sits directly downstream of the 1-to-8 path switch.
- Collects the eight data_inf streams, arbitrates one source at a time and forwards its beats, in order, onto a single master data_inf.
- A 2-entry output buffer decouples m00.ready from every upstream ready, so there is no combinational ready path.
- Held grants give per-source burst atomicity of up to HOLD_MAX beats.

Parameters:
- DSIZE, 8, data width of every data_inf port.
- HOLD_MAX, 16, maximum beats accepted per grant before forced re-arbitration (range 1..255).

Ports:
- clock  input  1  single clock domain
- rst  input  1  synchronous, active-high reset
- clk_en  input  1  global enable; no handshake completes while low
- s00..s07  data_inf.slaver  DSIZE  source streams: valid, data in; ready out
- m00  data_inf.master  DSIZE  merged stream: valid, data out; ready in
- curr_path  output  3  index of the granted source
- grant_vld  output  1  high while a grant is held (XFER)

Behaviour:
- Reset, sampled on the clock edge with rst high:
  - curr_path=0, grant_vld=0, state=ARB, buffer count=0, beat count=0, rr pointer=0.
  - m00.valid=0 and all s*.ready=0.
- Upstream transfer: s[i].valid & s[i].ready & clk_en.
- Downstream transfer: m00.valid & m00.ready & clk_en.
- State ARB:
  - On clk_en with any s*.valid high, register winner into curr_path.
  - Set grant_vld=1, clear beat count, go to XFER.
  - All s*.ready=0 in ARB.
  - No valid, or clk_en low: stay in ARB.
- State XFER:
  - s[curr_path].ready = clk_en & (buffer count<2). Every other s*.ready=0.
  - Each upstream transfer writes data into the buffer and increments beat count.
  - Return to ARB (grant_vld=0 next cycle) on either condition:
    - s[curr_path].valid is low on a clk_en cycle, or
    - an upstream transfer brings beat count to HOLD_MAX.
  - The buffer is not flushed on re-arbitration; beats keep their global order.
- Output buffer (2 entries):
  - m00.valid = clk_en & (count>0); m00.data = head entry.
  - Simultaneous push and pop: count unchanged, order kept.
  - Count 2 holds upstream ready low. Count 0 gives m00.valid low.
- Timing:
  - Minimum latency from upstream transfer to m00.valid is 1 cycle.
  - Sustained 1 beat/cycle inside a grant.
  - 1 idle ARB cycle between grants.
- Arbitration:
  - Round-robin: search starts at the rr pointer. After each grant, rr pointer = curr_path+1 (mod 8, wrap 7->0).
- clk_en low: state, counters and buffer are frozen, and all readies and m00.valid read 0.
- Reset mid-burst: buffered beats are discarded, and the block restarts in ARB the next cycle.
- Data on non-granted sources is ignored. An upstream valid dropped mid-burst ends the grant.

Optional Feature:
- Macro: DATA_PIPE_S8M1_FIXED_PRIO_EN.
- Defined: fixed priority (s00 highest, s07 lowest), and the rr pointer is removed.
- Undefined: round-robin as described above.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package data_pipe_pkg holds:
  - typedef enum logic[1:0] {ARB, XFER} s8m1_state_e
  - localparam NUM_PORTS=8 and PORT_W=3
- Sub-module data_pipe_skid2 #(DSIZE): the 2-entry buffer, with push/pop/count/head ports.
- Arbiter priority search stays inline.

Test Plan:
- Single source: s03 sends 0x11,0x22,0x33 back-to-back with m00.ready=1.
  - curr_path=3.
  - m00 delivers 0x11,0x22,0x33 on 3 consecutive cycles, first one 1 cycle after acceptance.
- Contention: s00 and s05 each send 4 beats continuously (RR build).
  - Order is s00 burst, 1 ARB cycle, s05 burst.
  - Next grant goes to s05+1 if it is valid.
- HOLD_MAX=16: s02 holds valid for 40 beats while s06 is valid.
  - Grants alternate s02(16), s06, s02(16), ...
  - grant_vld drops for exactly 1 cycle between grants.
- Backpressure: m00.ready=0 during s01 beats 0xA0..0xA5.
  - Exactly 2 accepted, then s01.ready=0.
  - After ready=1, all 6 beats arrive in order with no loss or duplication.
- clk_en pulses 1,0,1,0 during a burst.
  - Transfers occur only on clk_en=1 cycles.
  - m00.valid and s*.ready read 0 when clk_en=0.
- rst asserted with 2 beats buffered mid-burst.
  - Next cycle: m00.valid=0, grant_vld=0, curr_path=0.
  - Those beats never appear on m00.
